// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, decode-side queue head, and the execute-stage redirect.
// Handshakes: a memory read completes in the cycle mem_req && mem_ack; decode consumes the head in the cycle instr_valid && instr_ready.
interface fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instrucao;
  logic [31:0] pc_out;
  logic        instr_ready;

  modport master (
    output mem_req, mem_addr, instr_valid, instrucao, pc_out,
    input  mem_ack, mem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instrucao, pc_out,
    output mem_ack, mem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads words over req/ack, and queues up to two {pc, instr} entries for decode.
// Redirects flush the queue; a request already on the bus is drained and its data dropped.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  fetch_unit_if.master bus,
  output logic [1:0]  dbg_state_o,
  output logic [1:0]  dbg_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] e0_pc_q, e0_pc_d, e0_ins_q, e0_ins_d;
  logic [31:0] e1_pc_q, e1_pc_d, e1_ins_q, e1_ins_d;

  logic        pop;
  logic        push;
  logic        ack_fire;
  logic [31:0] redir_pc;

  assign bus.instr_valid = (count_q != 2'd0);
  assign bus.instrucao   = e0_ins_q;
  assign bus.pc_out      = e0_pc_q;
  assign pop             = bus.instr_valid && bus.instr_ready;
  assign redir_pc        = bus.redirect_pc & ~32'h0000_0003;

  // Request may only start while a slot is free (or being freed); once up it
  // stays up because the queue cannot fill without the ack that ends it.
  always_comb begin
    bus.mem_req = 1'b0;
    case (state_q)
      S_FETCH: bus.mem_req = (count_q < 2'd2) || pop;
      S_DRAIN: bus.mem_req = 1'b1;
      default: bus.mem_req = 1'b0;
    endcase
  end

  assign bus.mem_addr = (state_q == S_DRAIN) ? req_addr_q : pc_q;
  assign ack_fire     = bus.mem_req && bus.mem_ack;
  assign push         = (state_q == S_FETCH) && ack_fire && !bus.redirect;

  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    count_d    = count_q;
    e0_pc_d    = e0_pc_q;
    e0_ins_d   = e0_ins_q;
    e1_pc_d    = e1_pc_q;
    e1_ins_d   = e1_ins_q;
    if (state_q == S_FETCH) req_addr_d = pc_q;
    if (bus.redirect) begin
      pc_d    = redir_pc;
      count_d = 2'd0;
    end else begin
      if (push) pc_d = pc_q + 32'd4;
      case ({push, pop})
        2'b01: begin
          e0_pc_d  = e1_pc_q;
          e0_ins_d = e1_ins_q;
          count_d  = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_pc_d  = pc_q;
            e0_ins_d = bus.mem_rdata;
          end else begin
            e1_pc_d  = pc_q;
            e1_ins_d = bus.mem_rdata;
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_pc_d  = pc_q;
            e0_ins_d = bus.mem_rdata;
          end else begin
            e0_pc_d  = e1_pc_q;
            e0_ins_d = e1_ins_q;
            e1_pc_d  = pc_q;
            e1_ins_d = bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= 2'd0;
      e0_pc_q    <= 32'd0;
      e0_ins_q   <= 32'd0;
      e1_pc_q    <= 32'd0;
      e1_ins_q   <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      e0_pc_q    <= e0_pc_d;
      e0_ins_q   <= e0_ins_d;
      e1_pc_q    <= e1_pc_d;
      e1_ins_q   <= e1_ins_d;
      case (state_q)
        S_IDLE:  state_q <= S_FETCH;
        S_FETCH: if (bus.redirect && bus.mem_req && !bus.mem_ack) state_q <= S_DRAIN;
        S_DRAIN: if (bus.mem_ack) state_q <= S_FETCH;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;

endmodule
